// File: rtl/matmul_ctrl_if.sv
// Handshake and memory/MAC control bundle between matmul_ctrl and its surroundings.
// The slave side is the controller; the master side drives job requests and input beats.
interface matmul_ctrl_if #(
    parameter int AW = 4
);
    logic          start;
    logic          abort;
    logic          in_valid;
    logic          wr_en;
    logic          mem_sel;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          mac_en;
    logic          mac_clr;
    logic          out_valid;
    logic [AW-1:0] out_row;
    logic [AW-1:0] out_col;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, in_valid,
        input  wr_en, mem_sel, wr_addr, rd_addr_a, rd_addr_b,
               mac_en, mac_clr, out_valid, out_row, out_col, busy, done
    );

    modport slave (
        input  start, abort, in_valid,
        output wr_en, mem_sel, wr_addr, rd_addr_a, rd_addr_b,
               mac_en, mac_clr, out_valid, out_row, out_col, busy, done
    );
endinterface

// File: rtl/matmul_ctrl.sv
// Sequencer for an NxN matrix multiply: loads A then B from a byte stream, walks
// (i,j,k) over the operand memories and steers a MAC through its read latency.
module matmul_ctrl #(
    parameter int N  = 3,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    matmul_ctrl_if.slave  bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] MAC    = 3'd3;
    localparam logic [2:0] FLUSH1 = 3'd4;
    localparam logic [2:0] FLUSH2 = 3'd5;

    localparam logic [AW-1:0] NA      = AW'(N);
    localparam logic [AW-1:0] NM1     = AW'(N - 1);
    localparam logic [AW-1:0] LAST_LD = AW'(N * N - 1);

    logic [2:0]    state;
    logic [AW-1:0] ld_cnt, i_cnt, j_cnt, k_cnt;

    // Stage 1 lines up with the memory read data, stage 2 with the MAC result.
    logic          mac_en_q, mac_clr_q, last_q1, ov_q;
    logic [AW-1:0] row_q1, col_q1, row_q2, col_q2;

    logic in_load, in_mac, beat, last_k, last_j, last_i;

    assign in_load = (state == LOAD_A) || (state == LOAD_B);
    assign in_mac  = (state == MAC);
    assign beat    = in_load && bus.in_valid;
    assign last_k  = (k_cnt == NM1);
    assign last_j  = (j_cnt == NM1);
    assign last_i  = (i_cnt == NM1);

    always_ff @(posedge clk) begin
        if (!rst || bus.abort) begin
            state     <= IDLE;
            ld_cnt    <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            last_q1   <= 1'b0;
            ov_q      <= 1'b0;
            row_q1    <= '0;
            col_q1    <= '0;
            row_q2    <= '0;
            col_q2    <= '0;
        end else begin
            mac_en_q  <= in_mac;
            mac_clr_q <= in_mac && (k_cnt == '0);
            last_q1   <= in_mac && last_k;
            row_q1    <= i_cnt;
            col_q1    <= j_cnt;
            ov_q      <= last_q1;
            row_q2    <= row_q1;
            col_q2    <= col_q1;

            case (state)
                IDLE: if (bus.start) state <= LOAD_A;
                LOAD_A, LOAD_B: begin
                    if (beat) begin
                        if (ld_cnt == LAST_LD) begin
                            ld_cnt <= '0;
                            state  <= (state == LOAD_A) ? LOAD_B : MAC;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    // k innermost, then j, then i
                    if (!last_k) begin
                        k_cnt <= k_cnt + 1'b1;
                    end else begin
                        k_cnt <= '0;
                        if (!last_j) begin
                            j_cnt <= j_cnt + 1'b1;
                        end else begin
                            j_cnt <= '0;
                            if (!last_i) begin
                                i_cnt <= i_cnt + 1'b1;
                            end else begin
                                i_cnt <= '0;
                                state <= FLUSH1;
                            end
                        end
                    end
                end
                FLUSH1:  state <= FLUSH2;
                FLUSH2:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by rst so they read 0 for the whole reset cycle, not just after it.
    assign bus.wr_en     = rst && beat;
    assign bus.mem_sel   = rst && (state == LOAD_B);
    assign bus.wr_addr   = bus.wr_en ? ld_cnt : '0;
    assign bus.rd_addr_a = (rst && in_mac) ? i_cnt * NA + k_cnt : '0;
    assign bus.rd_addr_b = (rst && in_mac) ? k_cnt * NA + j_cnt : '0;
    assign bus.mac_en    = rst && mac_en_q;
    assign bus.mac_clr   = rst && mac_clr_q;
    assign bus.out_valid = rst && ov_q;
    assign bus.out_row   = bus.out_valid ? row_q2 : '0;
    assign bus.out_col   = bus.out_valid ? col_q2 : '0;
    assign bus.busy      = rst && (state != IDLE);
    assign bus.done      = rst && (state == FLUSH2);
endmodule

// File: tb/tb_matmul_ctrl.sv
// Scoreboard bench for matmul_ctrl (N=3): expected writes, reads and results are queued
// at job start and retired by a negedge monitor as the DUT strobes them.
module tb_matmul_ctrl;
    localparam int N  = 3;
    localparam int AW = 4;

    typedef struct packed { logic sel; logic [AW-1:0] addr; } wr_t;
    typedef struct packed { logic [AW-1:0] a; logic [AW-1:0] b; logic clr; } rd_t;
    typedef struct packed { logic [AW-1:0] row; logic [AW-1:0] col; logic [15:0] cyc; } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   t0 = 0;
    int   exp_done = 0;
    int   vecs = 0;
    int   errs = 0;
    bit   mon_en = 1'b0;
    bit   done_seen = 1'b0;
    logic [AW-1:0] prev_a = '0, prev_b = '0;
    logic [31:0]   all_out;

    wr_t  wr_q[$];
    rd_t  rd_q[$];
    res_t res_q[$];
    wr_t  we;
    rd_t  re;
    res_t se;

    matmul_ctrl_if #(.AW(AW)) bus ();

    matmul_ctrl #(.N(N), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign all_out = 32'({bus.wr_en, bus.mem_sel, bus.wr_addr, bus.rd_addr_a, bus.rd_addr_b,
                          bus.mac_en, bus.mac_clr, bus.out_valid, bus.out_row, bus.out_col,
                          bus.busy, bus.done});

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc - t0);
        end
    endtask

    // m0 is the relative cycle of the first MAC issue.
    task automatic gen_exp(input int m0);
        wr_q.delete(); rd_q.delete(); res_q.delete();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < N * N; a++)
                wr_q.push_back('{sel: 1'(s), addr: AW'(a)});
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < N; k++) begin
                    rd_q.push_back('{a: AW'(i * N + k), b: AW'(k * N + j), clr: (k == 0)});
                    if (k == N - 1)
                        res_q.push_back('{row: AW'(i), col: AW'(j),
                                          cyc: 16'(m0 + (i * N + j) * N + (N - 1) + 2)});
                end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.wr_en) begin
                if (wr_q.size() == 0) chk("wr_extra", 32'(1), 32'(0));
                else begin
                    we = wr_q.pop_front();
                    chk("wr_sel", 32'(bus.mem_sel), 32'(we.sel));
                    chk("wr_addr", 32'(bus.wr_addr), 32'(we.addr));
                end
            end else chk("wr_addr_idle", 32'(bus.wr_addr), 32'(0));

            if (bus.mac_en) begin
                if (rd_q.size() == 0) chk("mac_extra", 32'(1), 32'(0));
                else begin
                    re = rd_q.pop_front();
                    chk("rd_a", 32'(prev_a), 32'(re.a));
                    chk("rd_b", 32'(prev_b), 32'(re.b));
                    chk("mac_clr", 32'(bus.mac_clr), 32'(re.clr));
                end
            end else chk("mac_clr_idle", 32'(bus.mac_clr), 32'(0));

            if (bus.out_valid) begin
                if (res_q.size() == 0) chk("res_extra", 32'(1), 32'(0));
                else begin
                    se = res_q.pop_front();
                    chk("out_row", 32'(bus.out_row), 32'(se.row));
                    chk("out_col", 32'(bus.out_col), 32'(se.col));
                    chk("out_cyc", 32'(cyc - t0), 32'(se.cyc));
                end
            end else chk("out_idx_idle", 32'({bus.out_row, bus.out_col}), 32'(0));

            if (bus.done) begin
                chk("done_cyc", 32'(cyc - t0), 32'(exp_done));
                done_seen = 1'b1;
            end
        end
        prev_a = bus.rd_addr_a;
        prev_b = bus.rd_addr_b;
    end

    task automatic run_job(input bit gapped, input int exp_d);
        gen_exp(exp_d - 28);
        exp_done  = exp_d;
        done_seen = 1'b0;
        mon_en    = 1'b1;
        bus.start = 1'b1;
        t0 = cyc;
        bus.in_valid = !gapped;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n < 200 && !done_seen; n++) begin
            bus.in_valid = gapped ? (n % 2 == 1) : 1'b1;
            if (n == 18) begin
                @(negedge clk);
                chk("load_b_entry", 32'(bus.mem_sel), 32'(1));
            end
            if (n == 30) begin
                @(negedge clk);
                chk("busy_in_mac", 32'(bus.busy), 32'(1));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("done_seen", 32'(done_seen), 32'(1));
        chk("busy_after", 32'(bus.busy), 32'(0));
        chk("wr_q_left", 32'(wr_q.size()), 32'(0));
        chk("rd_q_left", 32'(rd_q.size()), 32'(0));
        chk("res_q_left", 32'(res_q.size()), 32'(0));
        mon_en = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    int bad;

    initial begin
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.in_valid = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("reset_outs", all_out, 32'(0));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        rst = 1'b1;

        run_job(1'b0, 47);
        run_job(1'b1, 64);

        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_start_idle", 32'(bus.busy), 32'(0));
        @(posedge clk); #1;

        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (cyc - t0 < 25) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre_abort_mac", 32'(bus.mac_en), 32'(1));
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.mac_en || bus.out_valid || bus.done || bus.busy || bus.wr_en) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'(0));
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        run_job(1'b0, 47);

        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (cyc - t0 < 12) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'(1));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", all_out, 32'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_after", all_out, 32'(0));
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        run_job(1'b0, 47);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 3, the square matrix dimension (2..15).
REQ-002 The block SHALL have parameter AW, default 4, the address width, with AW >= clog2(N*N).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, a job request sampled in IDLE only.
REQ-006 The block SHALL have port abort, input, 1, which cancels the job in progress.
REQ-007 The block SHALL have port in_valid, input, 1, which qualifies the external data_in byte stream.
REQ-008 The block SHALL have port wr_en, output, 1, the operand memory write strobe.
REQ-009 The block SHALL have port mem_sel, output, 1, the write target: 0 = matrix A, 1 = matrix B.
REQ-010 The block SHALL have port wr_addr, output, AW, the row-major write index.
REQ-011 The block SHALL have ports rd_addr_a and rd_addr_b, output, AW each, the synchronous-read addresses for A and B.
REQ-012 The block SHALL have port mac_en, output, 1, the MAC accumulate enable.
REQ-013 The block SHALL have port mac_clr, output, 1, which makes the MAC load the product instead of adding it.
REQ-014 The block SHALL have port out_valid, output, 1, which marks that the MAC accumulator holds finished C[out_row][out_col].
REQ-015 The block SHALL have ports out_row and out_col, output, AW each, the index of the finished C element.
REQ-016 The block SHALL have ports busy, output, 1, high whenever not in IDLE, and done, output, 1, a one-cycle job-complete pulse.

Function
REQ-017 The state machine SHALL have states IDLE, LOAD_A, LOAD_B, MAC, FLUSH1 and FLUSH2.
REQ-018 In IDLE, start=1 SHALL move the state to LOAD_A at the next edge; start SHALL be ignored in every other state.
REQ-019 In LOAD_A and LOAD_B, wr_en SHALL equal in_valid combinationally, and wr_addr SHALL equal the load counter.
REQ-020 In LOAD_A and LOAD_B, the load counter SHALL advance only on cycles with in_valid=1.
REQ-021 mem_sel SHALL be 0 in LOAD_A and 1 in LOAD_B.
REQ-022 After N*N accepted beats, LOAD_A SHALL go to LOAD_B and LOAD_B SHALL go to MAC, with the counter reset to 0.
REQ-023 in_valid SHALL be ignored outside the LOAD states.
REQ-024 In MAC, the block SHALL issue one (i,j,k) per cycle, k innermost, then j, then i, each running 0..N-1.
REQ-025 For each issued (i,j,k), rd_addr_a SHALL be i*N+k and rd_addr_b SHALL be k*N+j; both SHALL be 0 outside MAC.
REQ-026 mac_en SHALL be high in the cycle after each issue, to cover the 1-cycle memory read latency.
REQ-027 mac_clr SHALL be high in the cycle after each k=0 issue.
REQ-028 out_valid SHALL be high two cycles after each k=N-1 issue, with out_row=i and out_col=j of that issue.
REQ-029 Results SHALL be issued back-to-back with no idle cycles, giving one result every N cycles.
REQ-030 After issuing (N-1,N-1,N-1), the state SHALL go MAC -> FLUSH1 -> FLUSH2 -> IDLE.
REQ-031 mac_en SHALL be high in FLUSH1; out_valid and done SHALL be high in FLUSH2.
REQ-032 Latency from the start-sampling cycle to done SHALL be 2*N*N + N^3 + 2 cycles, assuming continuous in_valid.
REQ-033 abort=1 in any non-IDLE state SHALL move the state to IDLE at the next edge.
REQ-034 On abort, the block SHALL clear all counters and the delayed mac_en/mac_clr/out_valid pipeline, and SHALL NOT pulse done.
REQ-035 abort SHALL take priority over start and over all state transitions.
REQ-036 The combination abort=1 with start=1 in IDLE SHALL remain in IDLE.
REQ-037 out_row, out_col and wr_addr SHALL be 0 whenever their qualifying strobe is low.

Reset
REQ-038 rst=0 at a rising edge SHALL force state IDLE and clear all counters and pipeline registers, regardless of state, including mid-job.
REQ-039 While in reset, every output SHALL be 0, including busy and done.
REQ-040 The first start SHALL be accepted on the first edge with rst=1.

Verification
REQ-041 Reset scenario: rst=0 for 2 cycles with start=1 and in_valid=1 -> all outputs stay 0 and busy=0; no wr_en.
REQ-042 Load scenario: N=3, start pulse, then continuous in_valid -> 9 wr_en cycles with mem_sel=0 and wr_addr 0..8, then 9 with mem_sel=1 and wr_addr 0..8, then busy stays high in MAC.
REQ-043 Address scenario: for C[1][2], rd_addr_a SHALL be 3,4,5 and rd_addr_b SHALL be 2,5,8 on consecutive cycles; mac_clr with the first mac_en; out_valid with out_row=1 and out_col=2 two cycles after the last issue.
REQ-044 Timing scenario: start sampled at cycle 0 -> out_valid at cycles 23,26,...,47 (9 pulses), done only at cycle 47, busy low from cycle 48.
REQ-045 Gapped-input scenario: in_valid toggling 1,0,1,0 -> wr_addr advances only on valid beats; LOAD_B is entered after the 9th valid beat.
REQ-046 Abort and reset scenario: abort during MAC -> IDLE next cycle, no further mac_en, out_valid or done.
REQ-047 Abort and reset scenario: rst=0 mid-LOAD_B -> IDLE with outputs 0.
REQ-048 Abort and reset scenario: a new start after either case -> the job restarts at LOAD_A with wr_addr=0.
